// File: rtl/imem_fetch_responder_pkg.sv
// Shared constants and types for the instruction-memory fetch responder
// and any later stage that decodes the same instruction format.
package imem_fetch_responder_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W_DEF = 8;

    localparam logic [3:0] OP_JMP_DEF = 4'hC;
    localparam logic [3:0] OP_BRZ_DEF = 4'hD;

    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    // Instruction fields: opcode [15:12], jump target [11:0], displacement [7:0]
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int TGT_MSB  = 11;
    localparam int DISP_MSB = 7;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2
    } state_e;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [INSTR_W-1:0] jump_target(input logic [INSTR_W-1:0] instr);
        return {4'b0000, instr[TGT_MSB:0]};
    endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch bus and byte-serial program-load port between the PC/loader
// (master) and the instruction-memory responder (slave).
interface imem_fetch_responder_if
    import imem_fetch_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [INSTR_W-1:0] addr_imem_i;
    logic               zero_flag_i;
    logic               load_en_i;
    logic               ld_valid_i;
    logic [7:0]         ld_byte_i;
    logic               ld_ready_o;
    logic [ADDR_W-1:0]  ld_count_o;
    logic [INSTR_W-1:0] instr_o;
    logic               instr_valid_o;
    logic               addr_err_o;
    logic               jump_o;
    logic               branch_o;
    logic [7:0]         displacement_o;
    logic [INSTR_W-1:0] jump_tgt_o;

    modport slave (
        input  addr_imem_i, zero_flag_i, load_en_i, ld_valid_i, ld_byte_i,
        output ld_ready_o, ld_count_o, instr_o, instr_valid_o, addr_err_o,
               jump_o, branch_o, displacement_o, jump_tgt_o
    );

    modport master (
        output addr_imem_i, zero_flag_i, load_en_i, ld_valid_i, ld_byte_i,
        input  ld_ready_o, ld_count_o, instr_o, instr_valid_o, addr_err_o,
               jump_o, branch_o, displacement_o, jump_tgt_o
    );

endinterface

// File: rtl/imem_fetch_responder_instr_decode.sv
// Combinational decode of a registered instruction into PC control:
// jump/branch are qualified by valid; displacement and target always driven.
module imem_fetch_responder_instr_decode
    import imem_fetch_responder_pkg::*;
#(
    parameter logic [3:0] OP_JMP = OP_JMP_DEF,
    parameter logic [3:0] OP_BRZ = OP_BRZ_DEF
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               valid_i,
    input  logic               zero_flag_i,
    output logic               jump_o,
    output logic               branch_o,
    output logic [7:0]         displacement_o,
    output logic [INSTR_W-1:0] jump_tgt_o
);

    logic [3:0] opc;

    assign opc            = opcode_of(instr_i);
    assign jump_o         = valid_i && (opc == OP_JMP);
    assign branch_o       = valid_i && (opc == OP_BRZ) && zero_flag_i;
    assign displacement_o = instr_i[DISP_MSB:0];
    assign jump_tgt_o     = jump_target(instr_i);

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction memory with one-cycle registered fetch, out-of-range detection,
// and a byte-serial load FSM that fills the memory while fetch is stalled.
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter logic [3:0] OP_JMP = OP_JMP_DEF,
    parameter logic [3:0] OP_BRZ = OP_BRZ_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    imem_fetch_responder_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [INSTR_W-1:0] mem_q [DEPTH];

    state_e             state_q;
    logic [7:0]         hi_q;
    logic [ADDR_W-1:0]  ld_count_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               addr_err_q;

    logic               ld_ready;
    logic               ld_accept;
    logic               wr_en;
    logic               addr_oor;
    logic [INSTR_W-1:0] word_d;

    assign ld_ready  = (state_q != FETCH) && bus.load_en_i;
    assign ld_accept = ld_ready && bus.ld_valid_i;
    assign wr_en     = ld_accept && (state_q == LOAD_LO);
    assign word_d    = {hi_q, bus.ld_byte_i};
    assign addr_oor  = |bus.addr_imem_i[INSTR_W-1:ADDR_W];

    // Memory and the pending high byte are data only; neither is reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[ld_count_q] <= word_d;
        end
        if (ld_accept && (state_q == LOAD_HI)) begin
            hi_q <= bus.ld_byte_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FETCH;
            ld_count_q <= '0;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            // Any edge that does not fetch leaves a NOP marked invalid.
            instr_q    <= NOP;
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (bus.load_en_i) begin
                        state_q    <= LOAD_HI;
                        ld_count_q <= '0;
                    end else begin
                        valid_q <= 1'b1;
                        if (addr_oor) begin
                            addr_err_q <= 1'b1;
                        end else begin
                            instr_q <= mem_q[bus.addr_imem_i[ADDR_W-1:0]];
                        end
                    end
                end
                LOAD_HI: begin
                    if (!bus.load_en_i) begin
                        state_q <= FETCH;
                    end else if (bus.ld_valid_i) begin
                        state_q <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    // Leaving here discards the latched high byte.
                    if (!bus.load_en_i) begin
                        state_q <= FETCH;
                    end else if (bus.ld_valid_i) begin
                        state_q    <= LOAD_HI;
                        ld_count_q <= ld_count_q + 1'b1;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign bus.ld_ready_o    = ld_ready;
    assign bus.ld_count_o    = ld_count_q;
    assign bus.instr_o       = instr_q;
    assign bus.instr_valid_o = valid_q;
    assign bus.addr_err_o    = addr_err_q;

    imem_fetch_responder_instr_decode #(
        .OP_JMP(OP_JMP),
        .OP_BRZ(OP_BRZ)
    ) u_decode (
        .instr_i       (instr_q),
        .valid_i       (valid_q),
        .zero_flag_i   (bus.zero_flag_i),
        .jump_o        (bus.jump_o),
        .branch_o      (bus.branch_o),
        .displacement_o(bus.displacement_o),
        .jump_tgt_o    (bus.jump_tgt_o)
    );

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: a word-level memory model and
// PC-side expectations are queued at issue time and popped by a monitor.
module tb_imem_fetch_responder;
    import imem_fetch_responder_pkg::*;

    typedef struct {
        logic [15:0] instr;
        logic        err;
        logic        jmp;
        logic        brz;
        logic [7:0]  disp;
        logic [15:0] tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_responder_if #(.ADDR_W(8)) bus ();

    imem_fetch_responder #(.ADDR_W(8)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] ref_mem [256];
    int          ref_cnt;
    bit          ref_have_hi;
    logic [7:0]  ref_hi;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected PC-side view of one fetch, from the instruction format alone.
    function automatic exp_t model_fetch(input logic [15:0] a, input bit zf);
        exp_t e;
        int   w;
        if (a > 16'd255) begin
            e = '{16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
        end else begin
            w      = int'(ref_mem[a[7:0]]);
            e.instr = ref_mem[a[7:0]];
            e.err   = 1'b0;
            e.jmp   = ((w / 4096) == 12);
            e.brz   = ((w / 4096) == 13) && zf;
            e.disp  = 8'(w % 256);
            e.tgt   = 16'(w % 4096);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.instr_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got instr %0h with empty queue at %0t",
                             bus.instr_o, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr",    32'(bus.instr_o),        32'(mon_e.instr));
                    check("addr_err", 32'(bus.addr_err_o),     32'(mon_e.err));
                    check("jump",     32'(bus.jump_o),         32'(mon_e.jmp));
                    check("branch",   32'(bus.branch_o),       32'(mon_e.brz));
                    check("disp",     32'(bus.displacement_o), 32'(mon_e.disp));
                    check("jump_tgt", 32'(bus.jump_tgt_o),     32'(mon_e.tgt));
                end
            end else begin
                check("idle_instr",  32'(bus.instr_o),    32'h0);
                check("idle_err",    32'(bus.addr_err_o), 32'h0);
                check("idle_jump",   32'(bus.jump_o),     32'h0);
                check("idle_branch", 32'(bus.branch_o),   32'h0);
            end
        end
    end

    task automatic fetch_cycle(input logic [15:0] a, input bit zf);
        bus.addr_imem_i = a;
        exp_q.push_back(model_fetch(a, zf));
        @(posedge clk);
        #1;
        bus.zero_flag_i = zf;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        bus.ld_valid_i = 1'b1;
        bus.ld_byte_i  = b;
        #1;
        check("ld_ready", 32'(bus.ld_ready_o), 32'h1);
        @(posedge clk);
        if (!ref_have_hi) begin
            ref_hi      = b;
            ref_have_hi = 1'b1;
        end else begin
            ref_mem[ref_cnt] = {ref_hi, b};
            ref_cnt          = (ref_cnt + 1) % 256;
            ref_have_hi      = 1'b0;
        end
        #1;
        bus.ld_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic enter_load();
        bus.load_en_i = 1'b1;
        @(posedge clk);
        #1;
        ref_cnt     = 0;
        ref_have_hi = 1'b0;
    endtask

    task automatic exit_load(input bit with_byte, input logic [7:0] b);
        bus.load_en_i  = 1'b0;
        bus.ld_valid_i = with_byte;
        bus.ld_byte_i  = b;
        #1;
        check("ld_ready_exit", 32'(bus.ld_ready_o), 32'h0);
        @(posedge clk);
        #1;
        bus.ld_valid_i = 1'b0;
        ref_have_hi    = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr(input int hi_lim, input bit allow_oor);
        logic [15:0] a;
        if (allow_oor && ($urandom_range(0, 7) == 0)) begin
            a = {8'($urandom_range(1, 255)), 8'($urandom_range(0, 255))};
        end else begin
            a = 16'($urandom_range(0, hi_lim));
        end
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pc;
        int          pending;
        logic [15:0] w;

        rst             = 1'b1;
        bus.addr_imem_i = '0;
        bus.zero_flag_i = 1'b0;
        bus.load_en_i   = 1'b1;
        bus.ld_valid_i  = 1'b0;
        bus.ld_byte_i   = '0;
        ref_cnt         = 0;
        ref_have_hi     = 1'b0;
        ref_hi          = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_instr",    32'(bus.instr_o),       32'h0);
        check("rst_valid",    32'(bus.instr_valid_o), 32'h0);
        check("rst_err",      32'(bus.addr_err_o),    32'h0);
        check("rst_jump",     32'(bus.jump_o),        32'h0);
        check("rst_branch",   32'(bus.branch_o),      32'h0);
        check("rst_ld_ready", 32'(bus.ld_ready_o),    32'h0);
        check("rst_ld_count", 32'(bus.ld_count_o),    32'h0);
        rst = 1'b0;
        enter_load();

        // Basic load then fetch
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hC0);
        send_byte(8'h05);
        check("ld_count_basic", 32'(bus.ld_count_o), 32'd2);
        exit_load(1'b0, 8'h00);
        fetch_cycle(16'h0000, 1'($urandom_range(0, 1)));
        fetch_cycle(16'h0001, 1'($urandom_range(0, 1)));
        enter_load();
        check("ld_count_entry", 32'(bus.ld_count_o), 32'd0);

        // Program for branch, out-of-range and closed-loop tests
        send_word(16'h1234);
        send_word(16'hC005);
        send_word(16'hD0FE);
        send_word(16'hC010);
        send_word(16'h0ABC);
        for (int i = 5; i < 17; i++) send_word(16'($urandom));
        check("ld_count_17", 32'(bus.ld_count_o), 32'd17);
        exit_load(1'b0, 8'h00);
        fetch_cycle(16'h0002, 1'b1);
        fetch_cycle(16'h0002, 1'b0);
        fetch_cycle(16'h0100, 1'b1);
        pc      = 3;
        pending = -1;
        for (int i = 0; i < 3; i++) begin
            fetch_cycle(16'(pc), 1'b0);
            w = ref_mem[pc];
            if (pending >= 0) pc = pending;
            else              pc = pc + 1;
            pending = ((w / 4096) == 12) ? int'(w % 4096) : -1;
        end
        for (int i = 0; i < 30; i++) fetch_cycle(rand_addr(16, 1'b1), 1'($urandom_range(0, 1)));
        enter_load();

        // Partial-word abort, then byte coinciding with load_en falling
        send_word(16'($urandom));
        send_word(16'($urandom));
        send_byte(8'hAB);
        exit_load(1'b0, 8'h00);
        check("ld_count_abort", 32'(bus.ld_count_o), 32'd2);
        for (int i = 0; i < 4; i++) fetch_cycle(16'(i), 1'($urandom_range(0, 1)));
        enter_load();
        check("ld_count_reentry", 32'(bus.ld_count_o), 32'd0);
        send_word(16'($urandom));
        exit_load(1'b1, 8'hCD);
        check("ld_count_drop", 32'(bus.ld_count_o), 32'd1);
        for (int i = 0; i < 4; i++) fetch_cycle(16'(i), 1'($urandom_range(0, 1)));
        enter_load();

        // Count wrap: 257 words, the last overwrites word 0
        for (int i = 0; i < 257; i++) send_word(16'($urandom));
        check("ld_count_wrap", 32'(bus.ld_count_o), 32'd1);
        exit_load(1'b0, 8'h00);
        fetch_cycle(16'h0000, 1'b1);
        for (int i = 0; i < 60; i++) fetch_cycle(rand_addr(255, 1'b1), 1'($urandom_range(0, 1)));
        enter_load();

        // Asynchronous reset while in LOAD_LO
        send_word(16'hBEEF);
        send_byte(8'h77);
        #2;
        rst = 1'b1;
        #1;
        check("arst_instr",    32'(bus.instr_o),       32'h0);
        check("arst_valid",    32'(bus.instr_valid_o), 32'h0);
        check("arst_ld_ready", 32'(bus.ld_ready_o),    32'h0);
        check("arst_ld_count", 32'(bus.ld_count_o),    32'h0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        ref_cnt     = 0;
        ref_have_hi = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ld_ready", 32'(bus.ld_ready_o), 32'h1);
        exit_load(1'b0, 8'h00);
        fetch_cycle(16'h0000, 1'b0);
        fetch_cycle(16'h0001, 1'b0);
        for (int i = 0; i < 30; i++) fetch_cycle(rand_addr(255, 1'b1), 1'($urandom_range(0, 1)));
        enter_load();

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
